// File: rtl/burst_read_ptr.sv
// Read-side pointer for a circular buffer.
// Pops up to MAX_POP entries per cycle, clamps to occupancy, reports status and a sticky underflow.
module burst_read_ptr #(
    parameter int DEPTH      = 8,
    parameter int MAX_POP    = 4,
    parameter int AE_THRESH  = 2,
    parameter int PTR_WIDTH  = $clog2(DEPTH) + 1,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int POP_WIDTH  = $clog2(MAX_POP + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [POP_WIDTH-1:0]  pop_req,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic [PTR_WIDTH-1:0]  w_ptr,
    output logic [PTR_WIDTH-1:0]  r_ptr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [POP_WIDTH-1:0]  pop_gnt,
    output logic [PTR_WIDTH-1:0]  count,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow
);

    localparam logic [POP_WIDTH-1:0] MAX_POP_V = POP_WIDTH'(MAX_POP);
    localparam logic [PTR_WIDTH-1:0] AE_V      = PTR_WIDTH'(AE_THRESH);

    logic [POP_WIDTH-1:0] req_eff;
    logic [PTR_WIDTH-1:0] req_ext;
    logic                 uf_set;

    // MAX_POP <= DEPTH, so a request never needs more bits than the pointer.
    always_comb begin
        count   = w_ptr - r_ptr;
        req_eff = (pop_req > MAX_POP_V) ? MAX_POP_V : pop_req;
        req_ext = PTR_WIDTH'(req_eff);
        uf_set  = 1'b0;
        pop_gnt = '0;
        if (!flush) begin
            uf_set  = (req_ext > count);
            pop_gnt = uf_set ? POP_WIDTH'(count) : req_eff;
        end
    end

    assign empty        = (count == '0);
    assign almost_empty = (count <= AE_V);
    assign r_addr       = r_ptr[ADDR_WIDTH-1:0];

    // A new underflow takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            underflow <= 1'b0;
        end else begin
            r_ptr     <= flush ? w_ptr : r_ptr + PTR_WIDTH'(pop_gnt);
            underflow <= uf_set | (underflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_burst_read_ptr.sv
// Self-checking bench for burst_read_ptr: directed vector table, reset/async corner cases,
// and a randomized push/pop scoreboard.
module tb_burst_read_ptr;

    logic       clk;
    logic       rst_n;
    logic [2:0] pop_req;
    logic       flush;
    logic       clr_err;
    logic [3:0] w_ptr;
    logic [3:0] r_ptr;
    logic [2:0] r_addr;
    logic [2:0] pop_gnt;
    logic [3:0] count;
    logic       empty;
    logic       almost_empty;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    burst_read_ptr dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pop_req      (pop_req),
        .flush        (flush),
        .clr_err      (clr_err),
        .w_ptr        (w_ptr),
        .r_ptr        (r_ptr),
        .r_addr       (r_addr),
        .pop_gnt      (pop_gnt),
        .count        (count),
        .empty        (empty),
        .almost_empty (almost_empty),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int fl;
        int clr;
        int req;
        int w;
        int gnt;
        int cnt;
        int emp;
        int ae;
        int nr;
        int nuf;
    } vec_t;

    vec_t vecs[21];

    task automatic applyStimulus(input int fl, input int clr, input int req, input int w);
        flush   = 1'(fl);
        clr_err = 1'(clr);
        pop_req = 3'(req);
        w_ptr   = 4'(w);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkComb(input string tag, input int gnt, input int cnt, input int emp, input int ae);
        checkOutput({tag, " pop_gnt"}, int'(pop_gnt), gnt);
        checkOutput({tag, " count"}, int'(count), cnt);
        checkOutput({tag, " empty"}, int'(empty), emp);
        checkOutput({tag, " almost_empty"}, int'(almost_empty), ae);
    endtask

    task automatic checkRegs(input string tag, input int rp, input int uf);
        checkOutput({tag, " r_ptr"}, int'(r_ptr), rp);
        checkOutput({tag, " r_addr"}, int'(r_addr), rp & 7);
        checkOutput({tag, " underflow"}, int'(underflow), uf);
    endtask

    initial begin
        int mr, mw, muf, cnt, eff, gnt, nuf, push, room;
        int fl, clr, req;

        // fl clr req w | gnt cnt emp ae | next r_ptr, next underflow
        vecs[0]  = '{0, 0, 4,  6, 4, 6, 0, 0,  4, 0};
        vecs[1]  = '{0, 0, 0,  6, 0, 2, 0, 1,  4, 0};
        vecs[2]  = '{1, 0, 0, 12, 0, 8, 0, 0, 12, 0};
        vecs[3]  = '{1, 0, 0,  1, 0, 5, 0, 0,  1, 0};
        vecs[4]  = '{0, 0, 4,  3, 2, 2, 0, 1,  3, 1};
        vecs[5]  = '{0, 1, 0,  3, 0, 0, 1, 1,  3, 0};
        vecs[6]  = '{0, 1, 1,  3, 0, 0, 1, 1,  3, 1};
        vecs[7]  = '{0, 1, 0,  7, 0, 4, 0, 0,  3, 0};
        vecs[8]  = '{0, 0, 7,  7, 4, 4, 0, 0,  7, 0};
        vecs[9]  = '{1, 0, 0, 14, 0, 7, 0, 0, 14, 0};
        vecs[10] = '{1, 0, 0,  6, 0, 8, 0, 0,  6, 0};
        vecs[11] = '{0, 0, 3, 10, 3, 4, 0, 0,  9, 0};
        vecs[12] = '{0, 0, 4, 14, 4, 5, 0, 0, 13, 0};
        vecs[13] = '{0, 0, 1,  0, 1, 3, 0, 0, 14, 0};
        vecs[14] = '{0, 0, 2,  0, 2, 2, 0, 1,  0, 0};
        vecs[15] = '{0, 0, 0,  8, 0, 8, 0, 0,  0, 0};
        vecs[16] = '{1, 0, 4,  8, 0, 8, 0, 0,  8, 0};
        vecs[17] = '{0, 0, 0,  8, 0, 0, 1, 1,  8, 0};
        vecs[18] = '{0, 0, 4,  0, 4, 8, 0, 0, 12, 0};
        vecs[19] = '{0, 0, 0,  0, 0, 4, 0, 0, 12, 0};
        vecs[20] = '{1, 0, 4, 12, 0, 0, 1, 1, 12, 0};

        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0);
        #2;
        checkComb("reset", 0, 0, 1, 1);
        checkRegs("reset", 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 21; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].fl, vecs[i].clr, vecs[i].req, vecs[i].w);
            checkComb(tag, vecs[i].gnt, vecs[i].cnt, vecs[i].emp, vecs[i].ae);
            @(posedge clk); #1;
            checkRegs(tag, vecs[i].nr, vecs[i].nuf);
        end

        // Park r_ptr at 5 with underflow set, then hit reset between edges.
        applyStimulus(1, 0, 0, 5);
        @(posedge clk); #1;
        applyStimulus(0, 0, 1, 5);
        checkComb("park", 0, 0, 1, 1);
        @(posedge clk); #1;
        checkRegs("park", 5, 1);
        applyStimulus(0, 0, 2, 5);
        #2;
        rst_n = 1'b0;
        #1;
        checkRegs("async_reset", 0, 0);
        checkComb("async_reset", 2, 5, 0, 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkRegs("post_reset_edge", 2, 0);

        // Randomized push/pop against a reference model of the pointer pair.
        mr  = 2;
        mw  = 5;
        muf = 0;
        for (int c = 0; c < 10000; c++) begin
            fl  = ($urandom_range(0, 15) == 0) ? 1 : 0;
            clr = ($urandom_range(0, 7) == 0) ? 1 : 0;
            req = $urandom_range(0, 7);
            cnt = (mw - mr) & 15;
            eff = (req > 4) ? 4 : req;
            gnt = fl ? 0 : ((eff < cnt) ? eff : cnt);
            nuf = ((fl == 0 && eff > cnt) ? 1 : 0) | (muf & (clr ^ 1));
            applyStimulus(fl, clr, req, mw);
            checkOutput("rand pop_gnt", int'(pop_gnt), gnt);
            checkOutput("rand count", int'(count), cnt);
            if (int'(count) > 8) checkOutput("rand count_bound", int'(count), 8);
            @(posedge clk); #1;
            mr   = fl ? mw : ((mr + gnt) & 15);
            muf  = nuf;
            checkOutput("rand r_ptr", int'(r_ptr), mr);
            checkOutput("rand underflow", int'(underflow), muf);
            room = 8 - ((mw - mr) & 15);
            push = $urandom_range(0, room);
            mw   = (mw + push) & 15;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
